// File: rtl/instr_launcher_mp_pkg.sv
// Shared types and default sizing for the in-order launch stage.
// The lock table state is sized from these defaults, so top-level overrides must match them.
package instr_launcher_mp_pkg;

  localparam int unsigned DEF_NUM_REGS        = 64;
  localparam int unsigned DEF_NUM_OUTSTANDING = 7;
  localparam int unsigned DEF_NUM_CPL         = 2;
  localparam int unsigned REG_IDX_W           = $clog2(DEF_NUM_REGS);
  localparam int unsigned CNT_W               = $clog2(DEF_NUM_OUTSTANDING + 1);

  typedef struct packed {
    logic [7:0]           opcode;
    logic [REG_IDX_W-1:0] rd;
    logic [17:0]          imm;
  } decoded_instr_t;

  typedef struct packed {
    logic [DEF_NUM_REGS-1:0] locked;
    logic [CNT_W-1:0]        count;
    logic                    blk_pend;
  } launch_state_t;

endpackage

// File: rtl/reg_lock_table.sv
// Destination-register scoreboard: lock vector, in-flight count and blocking flag,
// with one set port, NUM_CPL clear ports, hazard detection and a sticky error.
module reg_lock_table
  import instr_launcher_mp_pkg::*;
#(
  parameter int unsigned NUM_CPL = DEF_NUM_CPL
) (
  input  logic                         clk_i,
  input  logic                         arst_ni,
  input  logic                         flush_i,
  input  logic                         set_i,
  input  logic [REG_IDX_W-1:0]         set_rd_i,
  input  logic                         set_blocking_i,
  input  logic [REG_IDX_W-1:0]         chk_rd_i,
  input  logic [DEF_NUM_REGS-1:0]      chk_req_i,
  input  logic [NUM_CPL-1:0]           cpl_valid_i,
  input  logic [NUM_CPL*REG_IDX_W-1:0] cpl_rd_i,
  output launch_state_t                state_o,
  output logic                         hazard_o,
  output logic                         err_o
);

  launch_state_t           st_q, st_d;
  logic                    err_q, err_d;
  logic [DEF_NUM_REGS-1:0] need;
  logic [REG_IDX_W-1:0]    cpl_rd;
  int                      pop;
  int                      cnt_next;

  always_comb begin
    need           = chk_req_i;
    need[chk_rd_i] = 1'b1;
    need[0]        = 1'b0;
  end

  // Only registered locks are consulted: a completion frees its register one cycle later.
  assign hazard_o = |(need & st_q.locked);

  always_comb begin
    st_d     = st_q;
    err_d    = err_q;
    pop      = 0;
    cpl_rd   = '0;
    cnt_next = 0;
    if (set_i && (set_rd_i != '0)) st_d.locked[set_rd_i] = 1'b1;
    for (int i = 0; i < int'(NUM_CPL); i++) begin
      if (cpl_valid_i[i]) begin
        cpl_rd = cpl_rd_i[i*REG_IDX_W +: REG_IDX_W];
        pop    = pop + 1;
        if (cpl_rd != '0) begin
          if (!st_q.locked[cpl_rd]) err_d = 1'b1;
          st_d.locked[cpl_rd] = 1'b0;
        end
      end
    end
    cnt_next = int'(st_q.count) + (set_i ? 1 : 0) - pop;
    if (cnt_next < 0) begin
      cnt_next = 0;
      err_d    = 1'b1;
    end
    st_d.count = CNT_W'(cnt_next);
    if (set_i) st_d.blk_pend = set_blocking_i;
    if (cnt_next == 0) st_d.blk_pend = 1'b0;
    if (flush_i) begin
      st_d  = '0;
      err_d = err_q;
    end
  end

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      st_q  <= '0;
      err_q <= 1'b0;
    end else begin
      st_q  <= st_d;
      err_q <= err_d;
    end
  end

  assign state_o = st_q;
  assign err_o   = err_q;

endmodule

// File: rtl/instr_launcher_mp.sv
// In-order launch stage: hazard/occupancy/blocking gating in front of a registered
// valid/ready output stage, with multi-port completion handled by reg_lock_table.
module instr_launcher_mp
  import instr_launcher_mp_pkg::*;
#(
  parameter int unsigned NUM_REGS        = DEF_NUM_REGS,
  parameter int unsigned NUM_OUTSTANDING = DEF_NUM_OUTSTANDING,
  parameter int unsigned NUM_CPL         = DEF_NUM_CPL,
  parameter int unsigned PAYLOAD_W       = $bits(decoded_instr_t)
) (
  input  logic                                   clk_i,
  input  logic                                   arst_ni,
  input  logic                                   flush_i,
  input  logic [PAYLOAD_W-1:0]                   in_payload_i,
  input  logic [$clog2(NUM_REGS)-1:0]            in_rd_i,
  input  logic [NUM_REGS-1:0]                    in_reg_req_i,
  input  logic                                   in_blocking_i,
  input  logic                                   in_valid_i,
  output logic                                   in_ready_o,
  output logic [PAYLOAD_W-1:0]                   out_payload_o,
  output logic                                   out_valid_o,
  input  logic                                   out_ready_i,
  input  logic [NUM_CPL-1:0]                     cpl_valid_i,
  input  logic [NUM_CPL*$clog2(NUM_REGS)-1:0]    cpl_rd_i,
  output logic [$clog2(NUM_OUTSTANDING+1)-1:0]   outstanding_o,
  output logic                                   err_o
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(NUM_OUTSTANDING);

  launch_state_t          st;
  logic                   hazard;
  logic                   accept;
  logic                   out_valid_q, out_valid_d;
  logic [PAYLOAD_W-1:0]   out_payload_q, out_payload_d;

  reg_lock_table #(
    .NUM_CPL (NUM_CPL)
  ) u_lock (
    .clk_i          (clk_i),
    .arst_ni        (arst_ni),
    .flush_i        (flush_i),
    .set_i          (accept),
    .set_rd_i       (in_rd_i),
    .set_blocking_i (in_blocking_i),
    .chk_rd_i       (in_rd_i),
    .chk_req_i      (in_reg_req_i),
    .cpl_valid_i    (cpl_valid_i),
    .cpl_rd_i       (cpl_rd_i),
    .state_o        (st),
    .hazard_o       (hazard),
    .err_o          (err_o)
  );

  // Readiness is a function of registered state and sideband inputs only, never of in_valid_i.
  assign in_ready_o = !flush_i && (!out_valid_q || out_ready_i) && !hazard &&
                      (st.count < MAX_CNT) && !st.blk_pend &&
                      (!in_blocking_i || (st.count == '0));
  assign accept     = in_valid_i && in_ready_o;

  always_comb begin
    out_valid_d   = out_valid_q;
    out_payload_d = out_payload_q;
    if (accept) begin
      out_valid_d   = 1'b1;
      out_payload_d = in_payload_i;
    end else if (out_ready_i) begin
      out_valid_d = 1'b0;
    end
    if (flush_i) out_valid_d = 1'b0;
  end

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      out_valid_q   <= 1'b0;
      out_payload_q <= '0;
    end else begin
      out_valid_q   <= out_valid_d;
      out_payload_q <= out_payload_d;
    end
  end

  assign out_valid_o   = out_valid_q;
  assign out_payload_o = out_payload_q;
  assign outstanding_o = st.count;

endmodule

// File: tb/tb_instr_launcher_mp.sv
// Directed bench for instr_launcher_mp: expected launches go into a scoreboard queue,
// a negedge monitor pops and compares on every output handshake.
module tb_instr_launcher_mp;
  import instr_launcher_mp_pkg::*;

  localparam int PW = $bits(decoded_instr_t);
  localparam int RW = $clog2(DEF_NUM_REGS);

  logic              clk_i = 1'b0;
  logic              arst_ni;
  logic              flush_i;
  logic [PW-1:0]     in_payload_i;
  logic [RW-1:0]     in_rd_i;
  logic [63:0]       in_reg_req_i;
  logic              in_blocking_i;
  logic              in_valid_i;
  logic              in_ready_o;
  logic [PW-1:0]     out_payload_o;
  logic              out_valid_o;
  logic              out_ready_i;
  logic [1:0]        cpl_valid_i;
  logic [2*RW-1:0]   cpl_rd_i;
  logic [2:0]        outstanding_o;
  logic              err_o;

  int            n_chk  = 0;
  int            n_fail = 0;
  logic [PW-1:0] exp_q[$];
  logic [PW-1:0] exp_v;

  instr_launcher_mp dut (
    .clk_i         (clk_i),
    .arst_ni       (arst_ni),
    .flush_i       (flush_i),
    .in_payload_i  (in_payload_i),
    .in_rd_i       (in_rd_i),
    .in_reg_req_i  (in_reg_req_i),
    .in_blocking_i (in_blocking_i),
    .in_valid_i    (in_valid_i),
    .in_ready_o    (in_ready_o),
    .out_payload_o (out_payload_o),
    .out_valid_o   (out_valid_o),
    .out_ready_i   (out_ready_i),
    .cpl_valid_i   (cpl_valid_i),
    .cpl_rd_i      (cpl_rd_i),
    .outstanding_o (outstanding_o),
    .err_o         (err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk_i) begin
    if (arst_ni === 1'b1 && out_valid_o === 1'b1 && out_ready_i === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL sb_unexpected: got payload %0h expected none", out_payload_o);
      end else begin
        exp_v = exp_q.pop_front();
        chk("sb_payload", out_payload_o, exp_v);
      end
    end
  end

  task automatic step();
    @(posedge clk_i);
    #1;
    cpl_valid_i = '0;
    cpl_rd_i    = '0;
    flush_i     = 1'b0;
  endtask

  task automatic send(input logic [RW-1:0] rd, input logic [63:0] req, input logic blk,
                      input logic [PW-1:0] pl);
    in_valid_i    = 1'b1;
    in_rd_i       = rd;
    in_reg_req_i  = req;
    in_blocking_i = blk;
    in_payload_i  = pl;
  endtask

  task automatic idle();
    in_valid_i    = 1'b0;
    in_rd_i       = '0;
    in_reg_req_i  = '0;
    in_blocking_i = 1'b0;
  endtask

  task automatic cpl(input logic v0, input logic [RW-1:0] r0, input logic v1, input logic [RW-1:0] r1);
    cpl_valid_i = {v1, v0};
    cpl_rd_i    = {r1, r0};
  endtask

  task automatic ready_is(input string name, input logic exp);
    #1;
    chk(name, in_ready_o, exp);
  endtask

  // Present an instruction expected to launch this cycle, record it, and clock it in.
  task automatic launch(input string name, input logic [RW-1:0] rd, input logic [63:0] req,
                        input logic blk, input logic [PW-1:0] pl);
    send(rd, req, blk, pl);
    ready_is(name, 1'b1);
    exp_q.push_back(pl);
    step();
    idle();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    arst_ni = 1'b0; flush_i = 1'b0; out_ready_i = 1'b1; in_payload_i = '0;
    cpl_valid_i = '0; cpl_rd_i = '0;
    idle();
    #2;
    chk("rst_out_valid", out_valid_o, 0);
    chk("rst_payload", out_payload_o, 0);
    chk("rst_outstanding", outstanding_o, 0);
    chk("rst_err", err_o, 0);
    repeat (2) step();
    arst_ni = 1'b1;
    ready_is("rst_ready", 1'b1);

    // back-to-back independent launches
    send(5, 64'd0, 0, 32'hA000_0005);
    ready_is("b2b_ready0", 1'b1);
    exp_q.push_back(32'hA000_0005);
    step();
    chk("b2b_valid1", out_valid_o, 1);
    send(6, 64'd0, 0, 32'hA000_0006);
    ready_is("b2b_ready1", 1'b1);
    exp_q.push_back(32'hA000_0006);
    step();
    idle();
    chk("b2b_outstanding", outstanding_o, 2);
    step();
    chk("b2b_valid_drop", out_valid_o, 0);

    // RAW: source 5 locked until its completion has been registered
    send(7, 64'd1 << 5, 0, 32'hB000_0007);
    ready_is("raw_stall0", 1'b0);
    step();
    ready_is("raw_stall1", 1'b0);
    cpl(1, 5, 0, 0);
    ready_is("raw_cpl_cycle", 1'b0);
    step();
    ready_is("raw_next_cycle", 1'b1);
    exp_q.push_back(32'hB000_0007);
    step();
    idle();
    chk("raw_outstanding", outstanding_o, 2);
    cpl(1, 6, 1, 7);
    step();
    chk("raw_drain", outstanding_o, 0);
    chk("raw_err", err_o, 0);

    // full: seven in flight, then two completions free a slot
    for (int r = 1; r <= 7; r++) launch("full_fill", RW'(r), 64'd0, 0, PW'(32'hC000_0000 + r));
    chk("full_count", outstanding_o, 7);
    send(8, 64'd0, 0, 32'hC000_0008);
    ready_is("full_held0", 1'b0);
    step();
    cpl(1, 1, 1, 2);
    ready_is("full_held_cpl", 1'b0);
    step();
    chk("full_after_cpl", outstanding_o, 5);
    ready_is("full_reenable", 1'b1);
    exp_q.push_back(32'hC000_0008);
    step();
    idle();
    chk("full_count6", outstanding_o, 6);
    cpl(1, 3, 1, 4); step();
    cpl(1, 5, 1, 6); step();
    cpl(1, 7, 1, 8); step();
    chk("full_drain", outstanding_o, 0);

    // blocking: waits for zero in flight, then holds off everything until it completes
    launch("blk_fill", 10, 64'd0, 0, 32'hD000_000A);
    launch("blk_fill", 11, 64'd0, 0, 32'hD000_000B);
    launch("blk_fill", 12, 64'd0, 0, 32'hD000_000C);
    send(0, 64'd0, 1, 32'hD000_00B0);
    ready_is("blk_wait3", 1'b0);
    cpl(1, 10, 0, 0);
    step();
    chk("blk_count2", outstanding_o, 2);
    cpl(1, 11, 1, 12);
    ready_is("blk_wait2", 1'b0);
    step();
    chk("blk_count0", outstanding_o, 0);
    ready_is("blk_launch", 1'b1);
    exp_q.push_back(32'hD000_00B0);
    step();
    send(9, 64'd0, 0, 32'hD000_0009);
    ready_is("blk_follow_stall0", 1'b0);
    step();
    ready_is("blk_follow_stall1", 1'b0);
    cpl(1, 0, 0, 0);
    ready_is("blk_follow_cpl_cycle", 1'b0);
    step();
    chk("blk_count_clear", outstanding_o, 0);
    ready_is("blk_follow_go", 1'b1);
    exp_q.push_back(32'hD000_0009);
    step();
    idle();
    chk("blk_err", err_o, 0);
    step();

    // backpressure then flush
    launch("bp_first", 13, 64'd0, 0, 32'hE000_000D);
    out_ready_i = 1'b0;
    send(14, 64'd0, 0, 32'hE000_000E);
    for (int c = 0; c < 4; c++) begin
      ready_is("bp_ready", 1'b0);
      chk("bp_payload", out_payload_o, 32'hE000_000D);
      chk("bp_valid", out_valid_o, 1);
      step();
    end
    flush_i = 1'b1;
    ready_is("flush_ready", 1'b0);
    step();
    idle();
    chk("flush_valid", out_valid_o, 0);
    chk("flush_outstanding", outstanding_o, 0);
    exp_q.delete();
    out_ready_i = 1'b1;
    launch("flush_unlocked", 20, (64'd1 << 9) | (64'd1 << 13), 0, 32'hE000_0014);

    // sticky error, flush retention, async reset, underflow
    cpl(1, 12, 0, 0);
    step();
    chk("err_set", err_o, 1);
    flush_i = 1'b1;
    step();
    chk("err_after_flush", err_o, 1);
    chk("err_flush_count", outstanding_o, 0);
    launch("pre_reset", 21, 64'd0, 0, 32'hF000_0015);
    arst_ni = 1'b0;
    #1;
    chk("arst_valid", out_valid_o, 0);
    chk("arst_payload", out_payload_o, 0);
    chk("arst_outstanding", outstanding_o, 0);
    chk("arst_err", err_o, 0);
    exp_q.delete();
    step();
    arst_ni = 1'b1;
    ready_is("arst_ready", 1'b1);
    cpl(1, 0, 0, 0);
    step();
    chk("underflow_err", err_o, 1);
    chk("underflow_count", outstanding_o, 0);
    step();
    chk("sb_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_launcher_mp.md
Name: instr_launcher_mp

Overview:
- Parametrised, multi-completion successor to the single-port launch stage.
- Sits between the decoder and the execution units and issues decoded instructions in order.
- Tracks locked destination registers (RAW/WAW hazards), caps in-flight instructions at NUM_OUTSTANDING, and serialises blocking instructions.
- Accepts NUM_CPL completions per cycle, supports flush, and drives a registered output stage with a valid/ready handshake.

Parameters:
- NUM_REGS, 64, architectural GPR+FPR count; FPRs are offset by 32; index 0 is x0 and is never locked.
- NUM_OUTSTANDING, 7, maximum number of launched, uncompleted instructions.
- NUM_CPL, 2, number of completion ports per cycle.
- PAYLOAD_W, $bits(decoded_instr_t), width of the opaque instruction payload passed through.

Ports:
- clk_i  in  1  clock.
- arst_ni  in  1  asynchronous, active-low reset.
- flush_i  in  1  synchronous flush.
- in_payload_i  in  PAYLOAD_W  decoded instruction.
- in_rd_i  in  $clog2(NUM_REGS)  destination register.
- in_reg_req_i  in  NUM_REGS  source registers required.
- in_blocking_i  in  1  instruction must execute alone.
- in_valid_i  in  1  input valid.
- in_ready_o  out  1  input accepted this cycle.
- out_payload_o  out  PAYLOAD_W  launched instruction (registered).
- out_valid_o  out  1  output valid.
- out_ready_i  in  1  downstream ready.
- cpl_valid_i  in  NUM_CPL  completion strobes.
- cpl_rd_i  in  NUM_CPL*$clog2(NUM_REGS)  rd of each completing instruction (0 if none).
- outstanding_o  out  $clog2(NUM_OUTSTANDING+1)  in-flight count.
- err_o  out  1  sticky: completion of an unlocked non-zero register, or count underflow.

Behaviour:
- Reset (arst_ni=0, asynchronous): locked=0, count=0, blk_pend=0, out_valid_o=0, out_payload_o=0, err_o=0.
- need = in_reg_req_i | onehot(in_rd_i); bit 0 of need is forced to 0.
- hazard = |(need & locked).
- Accept condition: in_ready_o = !flush_i & (!out_valid_o | out_ready_i) & !hazard & (count < NUM_OUTSTANDING) & !blk_pend & (!in_blocking_i | count==0).
- in_ready_o does not depend on in_valid_i. accept = in_valid_i & in_ready_o.
- On accept:
  - out_payload_o <= in_payload_i and out_valid_o <= 1 on the next edge (1-cycle latency).
  - locked[rd] <= 1 if rd != 0.
  - count increments.
  - blk_pend <= in_blocking_i.
- Output stage: out_valid_o clears when out_ready_i=1 and there is no accept. out_payload_o is held stable while out_valid_o & !out_ready_i.
- Completion, per port i with cpl_valid_i[i]:
  - locked[cpl_rd_i[i]] <= 0 (x0 ignored).
  - count decrements by popcount(cpl_valid_i).
  - If the rd is non-zero and not locked, err_o <= 1.
- blk_pend clears when next-count == 0.
- Count update: count_next = count + accept - popcount(cpl_valid_i). Underflow saturates at 0 and sets err_o.
- Hazard evaluation uses registered state only. A completion in cycle N unlocks for an accept in cycle N+1; there is no same-cycle bypass.
- An accept and a completion can never target the same register in one cycle, because an accept requires its rd to be unlocked. Duplicate rd across cpl ports in one cycle clears once and counts twice.
- Full: count==NUM_OUTSTANDING gives in_ready_o=0. A completion that cycle re-enables accept the next cycle.
- Blocking instruction: waits for count==0. After launch, no further accept until its completion drives count to 0.
- flush_i (priority over accept and completion): locked=0, count=0, blk_pend=0, out_valid_o=0. err_o is retained.
- Reset asserted mid-operation: every state element returns immediately to its reset value.

Decomposition:
- maverickOne_pkg: NUM_REGS, NUM_OUTSTANDING, decoded_instr_t; add NUM_CPL and a launch_state_t struct {locked, count, blk_pend}.
- One sub-module, reg_lock_table: holds the locked vector and count, applies multi-port set/clear, and outputs hazard and err.
- The output register stays in the top.

Test Plan:
- Back-to-back independent: rd=5 then rd=6, no reg_req, out_ready=1 → both accepted on consecutive cycles; out_valid high from cycle 1; outstanding=2.
- RAW: accept rd=5, then reg_req[5]=1 → in_ready_o=0 until cpl rd=5 in cycle N; accept in N+1, not N.
- Full: NUM_OUTSTANDING=7, 7 accepts with rd=1..7 → 8th held. Two simultaneous completions (rd=1, rd=2) → count=5, and the 8th is accepted next cycle.
- Blocking: count=3, blocking instruction presented → waits until 3 completions bring count to 0, launches, then a following rd=9 stalls until the blocking instruction's cpl (rd=0).
- Backpressure plus flush: out_ready_i=0 for 4 cycles → payload stable and in_ready_o=0. Then flush_i=1 → out_valid_o=0, outstanding_o=0, all registers unlocked.
- Error and reset: cpl rd=12 while unlocked → err_o=1 and sticky through flush. arst_ni pulse mid-stream → all outputs 0 immediately.
